// File: rtl/rs_chan_array_if.sv
// ---------------------------------------------------------------------------
// rs_chan_array_if
// Handshake/data bundle for rs_chan_array: per-channel valid/ready pairs on
// the upstream (in_*) and downstream (out_*) sides, with channel data packed
// as channel i at bits [i*DW +: DW].
//   master : the side that sources upstream data and sinks downstream data
//            (drives in_vld, in_data, out_rdy).
//   slave  : the buffer array itself (drives in_rdy, out_vld, out_data).
// ---------------------------------------------------------------------------
interface rs_chan_array_if #(
  parameter int CH = 2,
  parameter int DW = 32
);
  logic [CH-1:0]    in_vld;
  logic [CH-1:0]    in_rdy;
  logic [CH*DW-1:0] in_data;
  logic [CH-1:0]    out_vld;
  logic [CH-1:0]    out_rdy;
  logic [CH*DW-1:0] out_data;

  modport master (
    output in_vld, in_data, out_rdy,
    input  in_rdy, out_vld, out_data
  );

  modport slave (
    input  in_vld, in_data, out_rdy,
    output in_rdy, out_vld, out_data
  );
endinterface

// File: rtl/rs_chan_array.sv
// ---------------------------------------------------------------------------
// rs_chan_array
// Array of CH independent register slices with per-channel transfer counters.
//   MODE 0 : 2-entry skid buffer, one transfer per cycle sustained.
//   MODE 1 : 1-entry slice, at most one transfer every two cycles.
// in_rdy and out_vld come straight from flops; there is no combinational
// path from any input to any output.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (clears buffers, data, counters)
//   bus      : rs_chan_array_if.slave handshake/data bundle
//   cnt_clr  : zeroes every transfer counter on the next edge
//   xfer_cnt : per-channel saturating count of output transfers (CH*CNT_W)
//   occ      : per-channel buffer occupancy 0..2 (CH*2)
// ---------------------------------------------------------------------------
module rs_chan_array #(
  parameter int CH    = 2,
  parameter int DW    = 32,
  parameter int MODE  = 0,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  rs_chan_array_if.slave      bus,
  input  logic                cnt_clr,
  output logic [CH*CNT_W-1:0] xfer_cnt,
  output logic [CH*2-1:0]     occ
);

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [DW-1:0]    r_d0;       // head entry, drives out_data
    logic [DW-1:0]    r_d1;       // skid entry (MODE 0 only)
    logic [1:0]       r_occ;
    logic [1:0]       w_occ_nxt;
    logic             r_in_rdy;
    logic             r_out_vld;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push;
    logic             w_pop;
    logic [DW-1:0]    w_in;

    assign w_in   = bus.in_data[g*DW +: DW];
    assign w_push = bus.in_vld[g] & r_in_rdy;
    assign w_pop  = bus.out_rdy[g] & r_out_vld;

    always_comb begin
      w_occ_nxt = r_occ;
      if (w_push && !w_pop)
        w_occ_nxt = r_occ + 2'd1;
      else if (!w_push && w_pop)
        w_occ_nxt = r_occ - 2'd1;
    end

    // Stage boundary: buffer entries, flag flops and counter.
    // Ready/valid are registered from the next occupancy so they are flop
    // outputs yet already reflect this edge's push/pop.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_d0      <= '0;
        r_d1      <= '0;
        r_occ     <= 2'd0;
        r_in_rdy  <= 1'b0;
        r_out_vld <= 1'b0;
        r_cnt     <= '0;
      end else begin
        r_occ     <= w_occ_nxt;
        r_out_vld <= (w_occ_nxt != 2'd0);
        r_in_rdy  <= (MODE == 0) ? (w_occ_nxt != 2'd2) : (w_occ_nxt == 2'd0);

        // Head loads new data when empty, or when the single held entry
        // leaves in the same cycle; otherwise it advances from the skid.
        if (w_push && ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop)))
          r_d0 <= w_in;
        else if (w_pop && (r_occ == 2'd2))
          r_d0 <= r_d1;

        if (w_push && (r_occ == 2'd1) && !w_pop)
          r_d1 <= w_in;

        // Clear wins over a same-cycle increment.
        if (cnt_clr)
          r_cnt <= '0;
        else if (w_pop)
          r_cnt <= sat_inc(r_cnt);
      end
    end

    assign bus.in_rdy[g]               = r_in_rdy;
    assign bus.out_vld[g]              = r_out_vld;
    assign bus.out_data[g*DW +: DW]    = r_d0;
    assign xfer_cnt[g*CNT_W +: CNT_W]  = r_cnt;
    assign occ[g*2 +: 2]               = r_occ;
  end

endmodule

// File: doc/rs_chan_array.md
RS_CHAN_ARRAY -- requirements
Module: rs_chan_array

Interface
REQ-001 Parameter CH, default 2, number of independent channels (1..16).
REQ-002 Parameter DW, default 32, data width per channel (1..512).
REQ-003 Parameter MODE, default 0: 0 = full-throughput 2-entry skid, 1 = half-throughput 1-entry slice.
REQ-004 Parameter CNT_W, default 16, width of per-channel transfer counter.
REQ-005 Port clk  in  1  single clock; all logic on rising edge.
REQ-006 Port rst  in  1  synchronous, active-high reset.
REQ-007 Port in_vld  in  CH  per-channel upstream valid.
REQ-008 Port in_rdy  out  CH  per-channel upstream ready.
REQ-009 Port in_data  in  CH*DW  upstream data; channel i at bits [i*DW +: DW].
REQ-010 Port out_vld  out  CH  per-channel downstream valid.
REQ-011 Port out_rdy  in  CH  per-channel downstream ready.
REQ-012 Port out_data  out  CH*DW  downstream data; same packing as in_data.
REQ-013 Port cnt_clr  in  1  clears all transfer counters.
REQ-014 Port xfer_cnt  out  CH*CNT_W  per-channel count of completed output transfers.
REQ-015 Port occ  out  CH*2  per-channel buffer occupancy (0..2).

Function
REQ-016 Channels SHALL be fully independent; no state or timing coupling between channels.
REQ-017 Input transfer occurs when in_vld[i] & in_rdy[i]; output transfer when out_vld[i] & out_rdy[i].
REQ-018 in_data SHALL be sampled only on an input transfer; ignored otherwise.
REQ-019 Data SHALL leave each channel in arrival order, unmodified; no loss, no duplication.
REQ-020 Minimum latency SHALL be 1 cycle: data accepted in cycle N is presented on out_data in cycle N+1.
REQ-021 in_rdy and out_vld SHALL be driven directly from flops (no combinational in->out path).
REQ-022 While out_vld[i]=1 and out_rdy[i]=0, out_data[i] and out_vld[i] SHALL hold stable.
REQ-023 MODE 0: per-channel 2-entry buffer; in_rdy[i]=1 iff occ[i]<2; out_vld[i]=1 iff occ[i]>0.
REQ-024 MODE 0 occupancy update: push only -> +1; pop only -> -1; push and pop -> unchanged.
REQ-025 MODE 0: continuous in_vld=1/out_rdy=1 SHALL sustain one transfer per cycle.
REQ-026 MODE 0: out_rdy dropping for K cycles with occ=1 SHALL fill to occ=2, then in_rdy=0 next cycle; resumes one cycle after first pop.
REQ-027 MODE 1: single entry; in_rdy[i]=1 iff occ[i]=0; out_vld[i]=1 iff occ[i]=1; max throughput one transfer per 2 cycles.
REQ-028 MODE 1: simultaneous push/pop impossible (in_rdy=0 while full); pop returns occ to 0.
REQ-029 xfer_cnt[i] SHALL increment by 1 on each output transfer of channel i.
REQ-030 xfer_cnt SHALL saturate at 2^CNT_W-1; no wrap.
REQ-031 cnt_clr SHALL zero all counters next cycle; cnt_clr has priority over a same-cycle increment (result 0).
REQ-032 Buffer state SHALL be unaffected by cnt_clr.

Reset
REQ-033 While rst=1: occ=0, out_vld=0, in_rdy=0, out_data=0, xfer_cnt=0, all channels.
REQ-034 First cycle after rst deasserts: in_rdy=all ones (both modes).
REQ-035 Reset asserted mid-operation SHALL discard buffered data; no output transfer completes in the reset cycle.

Verification
REQ-036 MODE 0, CH=2, DW=8: ch0 streams 0x01..0x10 with out_rdy=1 -> out_data ch0 0x01..0x10 on consecutive cycles starting 1 cycle later; xfer_cnt[0]=16.
REQ-037 MODE 0: ch0 push 0xA1, 0xA2 with out_rdy=0 -> occ[0]=2, in_rdy[0]=0, out_data=0xA1 held; out_rdy=1 -> 0xA1 then 0xA2, in_rdy[0]=1 after first pop.
REQ-038 MODE 1: in_vld=1, out_rdy=1 continuous for 20 cycles -> exactly 10 output transfers, in_rdy alternating 1/0.
REQ-039 CNT_W=4: 20 transfers on ch1 -> xfer_cnt[1]=15 held; cnt_clr with concurrent transfer -> 0.
REQ-040 Channel isolation: ch0 out_rdy=0 stalled, ch1 streaming -> ch1 full rate, ch0 occ=2 unchanged.
REQ-041 rst pulsed with occ[0]=2 -> next cycle occ=0, out_vld=0, in_rdy=0; cycle after rst low in_rdy=1.
